// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file widths, counts and types
// Contents: XLEN default, REG_ADDR_W, NUM_REGS, reg_addr_t, xlen_t.
package rv_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters and RAW flags
// Optional feature: REGFILE_BYPASS_EN masks pending when a same-cycle retire clears it.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid/issue_wr/issue_rd  decode issue of a write to issue_rd
//   ret_valid/ret_rd           write-back retire (regWrite/WriteReg)
//   rs1_addr/rs2_addr          decode source indices
//   rs1_pending/rs2_pending    source has outstanding writes (combinational)
//   issue_full                 issue_rd counter saturated (combinational)
import rv_pkg::*;

module reg_scoreboard #(
    parameter int PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  ret_valid,
    input  logic [REG_ADDR_W-1:0] ret_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  issue_full
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] cnt [NUM_REGS];
    logic              inc;
    logic              dec;

    assign issue_full = (cnt[issue_rd] == CNT_MAX) && (issue_rd != '0);
    assign inc        = issue_valid && issue_wr && (issue_rd != '0) && !issue_full;
    // A retire against an idle counter is ignored so the counter never wraps.
    assign dec        = ret_valid && (ret_rd != '0) && (cnt[ret_rd] != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (inc && (issue_rd == reg_addr_t'(i)) && !(dec && (ret_rd == reg_addr_t'(i)))) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec && (ret_rd == reg_addr_t'(i)) && !(inc && (issue_rd == reg_addr_t'(i)))) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
            cnt[0] <= '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // The last outstanding write is being retired this cycle and nothing new
    // is issuing to it, so its value is already available via the data bypass.
    logic ret_clears;
    assign ret_clears  = dec && (cnt[ret_rd] == CNT_ONE) && !(inc && (issue_rd == ret_rd));
    assign rs1_pending = (cnt[rs1_addr] != '0) && (rs1_addr != '0) && !(ret_clears && (ret_rd == rs1_addr));
    assign rs2_pending = (cnt[rs2_addr] != '0) && (rs2_addr != '0) && !(ret_clears && (ret_rd == rs2_addr));
`else
    assign rs1_pending = (cnt[rs1_addr] != '0) && (rs1_addr != '0);
    assign rs2_pending = (cnt[rs2_addr] != '0) && (rs2_addr != '0);
`endif
endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 32-entry integer register file with write-back port and pending scoreboard
// Optional feature: REGFILE_BYPASS_EN forwards same-cycle WriteData to the read ports.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   regWrite/WriteReg/WriteData    write-back commit
//   rs1_addr/rs2_addr              read indices; rs1_data/rs2_data one cycle later
//   issue_valid/issue_rd/issue_wr  decode issue marking a destination pending
//   rs1_pending/rs2_pending        RAW hazard flags (combinational)
//   issue_full                     issue_rd counter saturated (combinational)
import rv_pkg::*;

module reg_file_wb #(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  regWrite,
    input  logic [REG_ADDR_W-1:0] WriteReg,
    input  logic [XLEN-1:0]       WriteData,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_wr,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  issue_full
);
    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_en;
    logic [XLEN-1:0] rd1_next;
    logic [XLEN-1:0] rd2_next;

    assign wr_en = regWrite && (WriteReg != '0);

    always_comb begin
        rd1_next = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rd2_next = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (WriteReg == rs1_addr)) begin
            rd1_next = WriteData;
        end
        if (wr_en && (WriteReg == rs2_addr)) begin
            rd2_next = WriteData;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            if (wr_en) begin
                regs[WriteReg] <= WriteData;
            end
            rs1_data <= rd1_next;
            rs2_data <= rd2_next;
        end
    end

    reg_scoreboard #(
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .ret_valid   (regWrite),
        .ret_rd      (WriteReg),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .issue_full  (issue_full)
    );
endmodule
